// File: rtl/spg_pkg.sv
// spike_pattern_gen shared types: FSM state, config entry, defaults.
// Imported by the top and the testbench.
package spg_pkg;

  localparam int SPG_N_CH  = 4;
  localparam int SPG_N_PAT = 2;
  localparam int SPG_DW    = 4;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } spg_state_e;

  typedef struct packed {
    logic              en;
    logic [SPG_DW-1:0] delay;
  } spg_cfg_t;

endpackage

// File: rtl/spike_pattern_gen_if.sv
// Config write bus of spike_pattern_gen: we, pat, ch, delay, en.
// master drives the bus, slave (the generator) samples it.
interface spike_pattern_gen_if #(
  parameter int N_CH  = 4,
  parameter int N_PAT = 2,
  parameter int DW    = 4
);
  localparam int PW = (N_PAT > 1) ? $clog2(N_PAT) : 1;
  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic          we;
  logic [PW-1:0] pat;
  logic [CW-1:0] ch;
  logic [DW-1:0] delay;
  logic          en;

  modport master (
    output we, pat, ch, delay, en
  );

  modport slave (
    input we, pat, ch, delay, en
  );
endinterface

// File: rtl/spg_max_delay.sv
// Masked maximum over N_CH delay fields (combinational).
// Ports: i_en enable mask, i_delay delays, o_max max (0 if none).
module spg_max_delay #(
  parameter int N_CH = 4,
  parameter int DW   = 4
) (
  input  logic [N_CH-1:0]         i_en,
  input  logic [N_CH-1:0][DW-1:0] i_delay,
  output logic [DW-1:0]           o_max
);

  always_comb begin
    o_max = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (i_en[c] && (i_delay[c] > o_max)) begin
        o_max = i_delay[c];
      end
    end
  end

endmodule

// File: rtl/spike_pattern_gen.sv
// Timed spatio-temporal spike pattern generator with config table.
// Ports: i_clk, i_rst_n (sync, active-low), i_trigger, cfg (config
// bus, slave), o_spike, o_busy, o_done, o_overrun.
// Build option SPG_RETRIGGER_EN: a trigger during RUN restarts the
// pattern instead of being dropped with an o_overrun pulse.
module spike_pattern_gen
  import spg_pkg::*;
#(
  parameter int N_CH  = SPG_N_CH,
  parameter int N_PAT = SPG_N_PAT,
  parameter int DW    = SPG_DW
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [N_PAT-1:0]  i_trigger,
  spike_pattern_gen_if.slave cfg,
  output logic [N_CH-1:0]   o_spike,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_overrun
);

  localparam int PW = (N_PAT > 1) ? $clog2(N_PAT) : 1;

`ifdef SPG_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  spg_cfg_t tbl [N_PAT][N_CH];

  spg_state_e state;
  logic [DW-1:0] cnt;
  logic [DW-1:0] max_d;
  logic [N_CH-1:0] snap_en;
  logic [N_CH-1:0][DW-1:0] snap_d;

  logic [PW-1:0] sel;
  logic [N_CH-1:0] row_en;
  logic [N_CH-1:0][DW-1:0] row_d;
  logic [DW-1:0] row_max;
  logic trig;
  logic restart;

  assign trig    = |i_trigger;
  assign restart = RETRIG && trig;

  // Lowest set trigger bit wins: scan downwards so it is written last.
  always_comb begin
    sel = '0;
    for (int p = N_PAT - 1; p >= 0; p--) begin
      if (i_trigger[p]) begin
        sel = PW'(p);
      end
    end
  end

  always_comb begin
    row_en = '0;
    row_d  = '0;
    for (int c = 0; c < N_CH; c++) begin
      row_en[c] = tbl[sel][c].en;
      row_d[c]  = tbl[sel][c].delay;
    end
  end

  spg_max_delay #(
    .N_CH (N_CH),
    .DW   (DW)
  ) u_max (
    .i_en    (row_en),
    .i_delay (row_d),
    .o_max   (row_max)
  );

  // Config table; the snapshot below reads the pre-write contents.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int p = 0; p < N_PAT; p++) begin
        for (int c = 0; c < N_CH; c++) begin
          tbl[p][c] <= '0;
        end
      end
    end else if (cfg.we && (int'(cfg.pat) < N_PAT)
                 && (int'(cfg.ch) < N_CH)) begin
      tbl[cfg.pat][cfg.ch] <= '{en: cfg.en, delay: cfg.delay};
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      max_d     <= '0;
      snap_en   <= '0;
      snap_d    <= '0;
      o_spike   <= '0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      o_spike   <= '0;
      o_done    <= 1'b0;
      o_overrun <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (trig) begin
            state   <= S_RUN;
            o_busy  <= 1'b1;
            snap_en <= row_en;
            snap_d  <= row_d;
            max_d   <= row_max;
            cnt     <= '0;
          end
        end
        S_RUN: begin
          if (restart) begin
            // Aborted pattern: no spike, no done.
            snap_en <= row_en;
            snap_d  <= row_d;
            max_d   <= row_max;
            cnt     <= '0;
          end else begin
            for (int c = 0; c < N_CH; c++) begin
              o_spike[c] <= snap_en[c] && (snap_d[c] == cnt);
            end
            cnt       <= cnt + 1'b1;
            o_overrun <= trig;
            if (cnt == max_d) begin
              state  <= S_IDLE;
              o_busy <= 1'b0;
              o_done <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spike_pattern_gen.sv
// Scoreboard bench for spike_pattern_gen: timing model + queue.
// Honours SPG_RETRIGGER_EN when the design is built with it.
module tb_spike_pattern_gen;
  import spg_pkg::*;

  localparam int N_CH  = 4;
  localparam int N_PAT = 2;
  localparam int DW    = 4;

`ifdef SPG_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  typedef struct {
    int              cyc;
    logic [N_CH-1:0] spike;
    logic            busy;
    logic            done;
    logic            ovr;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic [N_PAT-1:0] trigger;
  logic [N_CH-1:0]  spike;
  logic             busy;
  logic             done;
  logic             overrun;

  spike_pattern_gen_if #(
    .N_CH(N_CH), .N_PAT(N_PAT), .DW(DW)
  ) cfg_bus ();

  spike_pattern_gen #(
    .N_CH(N_CH), .N_PAT(N_PAT), .DW(DW)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_trigger (trigger),
    .cfg       (cfg_bus.slave),
    .o_spike   (spike),
    .o_busy    (busy),
    .o_done    (done),
    .o_overrun (overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t q[$];

  // Reference model: timing stated as edge arithmetic.
  bit m_en [N_PAT][N_CH];
  int m_d  [N_PAT][N_CH];
  bit act = 0;
  int s_edge = 0;
  int s_max = 0;
  bit s_en [N_CH];
  int s_d  [N_CH];

  task automatic load(input logic [N_PAT-1:0] t, input int k);
    int sel;
    sel = 0;
    for (int p = N_PAT - 1; p >= 0; p--) if (t[p]) sel = p;
    s_max = 0;
    for (int c = 0; c < N_CH; c++) begin
      s_en[c] = m_en[sel][c];
      s_d[c]  = m_d[sel][c];
      if (s_en[c] && s_d[c] > s_max) s_max = s_d[c];
    end
    s_edge = k;
    act = 1;
  endtask

  task automatic model(input logic r, input logic [N_PAT-1:0] t,
                       input logic we, input int p, input int c,
                       input int d, input logic e, input int k);
    exp_t x;
    x.cyc = k; x.spike = '0; x.busy = 0; x.done = 0; x.ovr = 0;
    if (!r) begin
      for (int i = 0; i < N_PAT; i++)
        for (int j = 0; j < N_CH; j++) begin
          m_en[i][j] = 0; m_d[i][j] = 0;
        end
      act = 0;
      return;
    end
    if (act && k <= s_edge + 1 + s_max) begin
      for (int j = 0; j < N_CH; j++)
        x.spike[j] = s_en[j] && (k == s_edge + 1 + s_d[j]);
      x.done = (k == s_edge + 1 + s_max);
      if (x.done) act = 0;
      if (t != 0) begin
        if (RETRIG) begin
          x.spike = '0; x.done = 0;
          load(t, k);
        end else begin
          x.ovr = 1;
        end
      end
    end else if (t != 0) begin
      load(t, k);
    end
    x.busy = act && (k < s_edge + 1 + s_max);
    if (we) begin
      m_en[p][c] = e; m_d[p][c] = d;
    end
    if (x.spike != 0 || x.busy || x.done || x.ovr) q.push_back(x);
  endtask

  // Drive one cycle's inputs at the negedge for the coming edge.
  task automatic step(input logic r, input logic [N_PAT-1:0] t,
                      input logic we, input int p, input int c,
                      input int d, input logic e);
    rst_n = r;
    trigger = t;
    cfg_bus.we = we;
    cfg_bus.pat = 1'(p);
    cfg_bus.ch = 2'(c);
    cfg_bus.delay = 4'(d);
    cfg_bus.en = e;
    model(r, t, we, p, c, d, e, cyc + 1);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input int p, input int c, input int d, input logic e);
    step(1, 0, 1, p, c, d, e);
  endtask

  // Monitor: pops an expectation whenever the DUT shows activity.
  always @(posedge clk) begin
    exp_t x;
    #1;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      x = q.pop_front();
      n_checks++; n_fail++;
      $display("FAIL missing cyc=%0d got none want spike=%b busy=%b done=%b ovr=%b",
               x.cyc, x.spike, x.busy, x.done, x.ovr);
    end
    if (spike != 0 || busy || done || overrun) begin
      n_checks++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected cyc=%0d got spike=%b busy=%b done=%b ovr=%b want idle",
                 cyc, spike, busy, done, overrun);
      end else begin
        x = q.pop_front();
        if (x.cyc != cyc || x.spike != spike || x.busy != busy
            || x.done != done || x.ovr != overrun) begin
          n_fail++;
          $display("FAIL outputs cyc=%0d got spike=%b busy=%b done=%b ovr=%b want cyc=%0d spike=%b busy=%b done=%b ovr=%b",
                   cyc, spike, busy, done, overrun,
                   x.cyc, x.spike, x.busy, x.done, x.ovr);
        end
      end
    end
  end

  initial begin
    rst_n = 0; trigger = '0;
    cfg_bus.we = 0; cfg_bus.pat = '0; cfg_bus.ch = '0;
    cfg_bus.delay = '0; cfg_bus.en = 0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0);
    idle(1);
    n_checks++;
    if ({spike, busy, done, overrun} != '0) begin
      n_fail++;
      $display("FAIL reset_state got %b want 0",
               {spike, busy, done, overrun});
    end

    // Basic pattern.
    wr(0, 0, 1, 1);
    wr(0, 2, 3, 1);
    step(1, 2'b01, 0, 0, 0, 0, 0);
    idle(8);
    // Equal delays on pattern 1.
    wr(1, 1, 2, 1);
    wr(1, 3, 2, 1);
    step(1, 2'b10, 0, 0, 0, 0, 0);
    idle(6);
    // Simultaneous triggers.
    step(1, 2'b11, 0, 0, 0, 0, 0);
    idle(6);
    // Trigger during RUN.
    wr(0, 0, 5, 1);
    wr(0, 2, 0, 0);
    step(1, 2'b01, 0, 0, 0, 0, 0);
    idle(1);
    step(1, 2'b01, 0, 0, 0, 0, 0);
    idle(10);
    // Back-to-back: retrigger exactly on the done edge, then next edge.
    wr(0, 0, 1, 1);
    step(1, 2'b01, 0, 0, 0, 0, 0);
    idle(1);
    step(1, 2'b01, 0, 0, 0, 0, 0);
    step(1, 2'b01, 0, 0, 0, 0, 0);
    idle(6);
    // Config write during RUN.
    step(1, 2'b01, 0, 0, 0, 0, 0);
    wr(0, 0, 7, 1);
    idle(5);
    step(1, 2'b01, 0, 0, 0, 0, 0);
    idle(10);
    // Reset mid-pattern, then an all-disabled run.
    wr(0, 0, 3, 1);
    step(1, 2'b01, 0, 0, 0, 0, 0);
    idle(1);
    step(0, 0, 0, 0, 0, 0, 0);
    idle(3);
    step(1, 2'b01, 0, 0, 0, 0, 0);
    idle(4);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      logic r;
      logic [N_PAT-1:0] t;
      logic we;
      r  = ($urandom_range(0, 199) != 0);
      t  = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      we = ($urandom_range(0, 2) == 0);
      step(r, t, we, $urandom_range(0, N_PAT - 1),
           $urandom_range(0, N_CH - 1), $urandom_range(0, 15),
           1'($urandom_range(0, 1)));
    end
    idle(20);

    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
